// File: rtl/weight_mem_sched_if.sv
// Requester-side bus of the weight store scheduler: trainer writes plus predictor and debug reads.
interface weight_mem_sched_if #(
    parameter int unsigned ADDR_W = 7
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_gnt;
    logic              wr_done;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic [7:0]        rdata;
    logic              rvalid;
    logic              addr_err;
    logic              busy;
    logic              clear_done;

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, dbg_req, dbg_addr,
        input  wr_gnt, wr_done, rd_gnt, dbg_gnt, rdata, rvalid, addr_err, busy, clear_done
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, dbg_req, dbg_addr,
        output wr_gnt, wr_done, rd_gnt, dbg_gnt, rdata, rvalid, addr_err, busy, clear_done
    );
endinterface

// File: rtl/weight_mem_sched.sv
// Weight store sequencer: post-reset clear sweep, then arbitrated trainer writes and
// predictor/debug reads over a lower and an upper single-port latch bank.
module weight_mem_sched #(
    parameter int unsigned MEM_BYTES   = 96,
    parameter int unsigned LOWER_BYTES = 64,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned WR_HOLD     = 2,
    parameter int unsigned DBG_STARVE  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    weight_mem_sched_if.slave bus,
    output logic [5:0]        lo_addr,
    output logic              lo_we,
    output logic [ADDR_W-2:0] hi_addr,
    output logic              hi_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        lo_rdata,
    input  logic [7:0]        hi_rdata
);
    localparam int unsigned PH_W  = $clog2(WR_HOLD + 1);
    localparam int unsigned CNT_W = $clog2(DBG_STARVE + 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_WRITE,
        S_RD_ADDR,
        S_RD_WAIT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [PH_W-1:0]   ph;
    logic [CNT_W-1:0]  starve_cnt;
    logic              oor_q;

    logic              any_req_c;
    logic              pick_wr_c;
    logic              pick_rd_c;
    logic              pick_dbg_c;
    logic [ADDR_W-1:0] pick_addr_c;
    logic              hold_end_c;
    logic              release_end_c;
    logic              load_c;
    logic              load_we_c;
    logic              load_lower_c;
    logic [ADDR_W-1:0] load_addr_c;

    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} >= (ADDR_W+1)'(MEM_BYTES);
    endfunction

    // Arbitration and the address/we load shared by the clear sweep and new grants
    always_comb begin
        any_req_c     = bus.wr_req | bus.rd_req | bus.dbg_req;
        pick_wr_c     = bus.wr_req;
        pick_dbg_c    = !bus.wr_req && bus.dbg_req &&
                        (!bus.rd_req || (starve_cnt >= CNT_W'(DBG_STARVE)));
        pick_rd_c     = !bus.wr_req && bus.rd_req && !pick_dbg_c;
        pick_addr_c   = pick_wr_c ? bus.wr_addr : (pick_rd_c ? bus.rd_addr : bus.dbg_addr);
        hold_end_c    = (ph == PH_W'(WR_HOLD - 1));
        release_end_c = (ph == PH_W'(WR_HOLD));
        load_c        = 1'b0;
        load_we_c     = 1'b0;
        load_addr_c   = addr;
        if (state == S_CLEAR && release_end_c && addr != ADDR_W'(MEM_BYTES - 1)) begin
            load_c      = 1'b1;
            load_we_c   = 1'b1;
            load_addr_c = addr + ADDR_W'(1);
        end else if (state == S_IDLE && any_req_c) begin
            load_c      = 1'b1;
            load_we_c   = pick_wr_c && !out_of_range(pick_addr_c);
            load_addr_c = pick_addr_c;
        end
        load_lower_c  = (load_addr_c < ADDR_W'(LOWER_BYTES));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_CLEAR;
            addr         <= '0;
            ph           <= '0;
            starve_cnt   <= '0;
            oor_q        <= 1'b0;
            lo_addr      <= '0;
            hi_addr      <= '0;
            lo_we        <= 1'b1;
            hi_we        <= 1'b0;
            mem_wdata    <= 8'h00;
            bus.wr_gnt   <= 1'b0;
            bus.rd_gnt   <= 1'b0;
            bus.dbg_gnt  <= 1'b0;
            bus.wr_done  <= 1'b0;
            bus.rvalid   <= 1'b0;
            bus.addr_err <= 1'b0;
            bus.rdata    <= 8'h00;
            bus.busy     <= 1'b1;
            bus.clear_done <= 1'b0;
        end else begin
            bus.wr_gnt   <= 1'b0;
            bus.rd_gnt   <= 1'b0;
            bus.dbg_gnt  <= 1'b0;
            bus.wr_done  <= 1'b0;
            bus.rvalid   <= 1'b0;
            bus.addr_err <= 1'b0;
            if (!bus.dbg_req) starve_cnt <= '0;

            // Steering: only the bank owning the address gets a new address or a we
            if (load_c) begin
                addr  <= load_addr_c;
                ph    <= '0;
                lo_we <= load_we_c && load_lower_c;
                hi_we <= load_we_c && !load_lower_c;
                if (load_lower_c) lo_addr <= load_addr_c[5:0];
                else              hi_addr <= (ADDR_W-1)'(load_addr_c - ADDR_W'(LOWER_BYTES));
            end

            case (state)
                S_CLEAR, S_WRITE: begin
                    if (!release_end_c) ph <= ph + PH_W'(1);
                    if (hold_end_c) begin
                        lo_we <= 1'b0;
                        hi_we <= 1'b0;
                    end
                    if (release_end_c) begin
                        if (state == S_WRITE) begin
                            bus.wr_done <= 1'b1;
                            bus.busy    <= 1'b0;
                            state       <= S_IDLE;
                        end else if (addr == ADDR_W'(MEM_BYTES - 1)) begin
                            bus.clear_done <= 1'b1;
                            bus.busy       <= 1'b0;
                            state          <= S_IDLE;
                        end
                    end
                end
                S_IDLE: begin
                    if (any_req_c) begin
                        oor_q        <= out_of_range(pick_addr_c);
                        bus.addr_err <= out_of_range(pick_addr_c);
                        bus.busy     <= 1'b1;
                        if (pick_wr_c) begin
                            bus.wr_gnt <= 1'b1;
                            mem_wdata  <= bus.wr_data;
                            state      <= S_WRITE;
                        end else begin
                            bus.rd_gnt  <= pick_rd_c;
                            bus.dbg_gnt <= pick_dbg_c;
                            state       <= S_RD_ADDR;
                        end
                    end
                    // A pending debug request that loses this arbitration ages toward priority
                    if (bus.dbg_req) begin
                        if (pick_dbg_c)                                starve_cnt <= '0;
                        else if (starve_cnt != CNT_W'(DBG_STARVE))     starve_cnt <= starve_cnt + CNT_W'(1);
                    end
                end
                S_RD_ADDR: state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    if (oor_q)                             bus.rdata <= 8'h00;
                    else if (addr < ADDR_W'(LOWER_BYTES))  bus.rdata <= lo_rdata;
                    else                                   bus.rdata <= hi_rdata;
                    bus.rvalid <= 1'b1;
                    bus.busy   <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_weight_mem_sched.sv
// Self-checking bench for weight_mem_sched: clear sweep, vector table, corner sequences, random traffic.
module tb_weight_mem_sched;
    localparam int unsigned MEM_BYTES   = 96;
    localparam int unsigned LOWER_BYTES = 64;
    localparam int unsigned ADDR_W      = 7;
    localparam int unsigned WR_HOLD     = 2;
    localparam int unsigned CLEAR_EDGES = MEM_BYTES * (WR_HOLD + 1);

    typedef struct {
        int         op;       // 0 write, 1 predictor read, 2 debug read
        int         addr;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic [5:0]        lo_addr;
    logic              lo_we;
    logic [ADDR_W-2:0] hi_addr;
    logic              hi_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        lo_rdata;
    logic [7:0]        hi_rdata;
    logic [7:0]        lo_mem [64] = '{default: 8'hA5};
    logic [7:0]        hi_mem [64] = '{default: 8'hA5};
    logic [7:0]        ref_mem [128];
    int                checks;
    int                errors;

    weight_mem_sched_if #(.ADDR_W(ADDR_W)) bus ();

    weight_mem_sched #(
        .MEM_BYTES(MEM_BYTES), .LOWER_BYTES(LOWER_BYTES), .ADDR_W(ADDR_W),
        .WR_HOLD(WR_HOLD), .DBG_STARVE(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .lo_addr(lo_addr), .lo_we(lo_we), .hi_addr(hi_addr), .hi_we(hi_we),
        .mem_wdata(mem_wdata), .lo_rdata(lo_rdata), .hi_rdata(hi_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank models: write on a clock edge with we high, asynchronous read
    always @(posedge clk) begin
        if (lo_we) lo_mem[lo_addr] <= mem_wdata;
        if (hi_we) hi_mem[hi_addr] <= mem_wdata;
    end
    assign lo_rdata = lo_mem[lo_addr];
    assign hi_rdata = hi_mem[hi_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_gnt(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            case (which)
                0:       ok = bus.wr_gnt;
                1:       ok = bus.rd_gnt;
                default: ok = bus.dbg_gnt;
            endcase
        end
    endtask

    task automatic do_write(input int a, input logic [7:0] d, input logic exp_err, input string name);
        bit ok;
        bit lower;
        bit we;
        bus.wr_req  = 1'b1;
        bus.wr_addr = ADDR_W'(a);
        bus.wr_data = d;
        wait_gnt(0, ok);
        bus.wr_req = 1'b0;
        if (!ok) begin
            check({name, "/wr_gnt_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({name, "/addr_err"}, 32'(bus.addr_err), 32'(exp_err));
        lower = (a < LOWER_BYTES);
        for (int k = 0; k < WR_HOLD + 1; k++) begin
            we = (k < WR_HOLD) && !exp_err;
            check({name, "/lo_we"}, 32'(lo_we), 32'(we && lower));
            check({name, "/hi_we"}, 32'(hi_we), 32'(we && !lower));
            if (we && lower)  check({name, "/lo_addr"}, 32'(lo_addr), 32'(a));
            if (we && !lower) check({name, "/hi_addr"}, 32'(hi_addr), 32'(a - 64));
            if (we)           check({name, "/mem_wdata"}, 32'(mem_wdata), 32'(d));
            if (k > 0)        check({name, "/wr_gnt_width"}, 32'(bus.wr_gnt), 32'd0);
            check({name, "/wr_done_early"}, 32'(bus.wr_done), 32'd0);
            tick();
        end
        check({name, "/wr_done"}, 32'(bus.wr_done), 32'd1);
    endtask

    task automatic do_read(input int a, input bit dbg, input logic [7:0] exp_d,
                           input logic exp_err, input string name);
        bit ok;
        if (dbg) begin
            bus.dbg_req  = 1'b1;
            bus.dbg_addr = ADDR_W'(a);
        end else begin
            bus.rd_req  = 1'b1;
            bus.rd_addr = ADDR_W'(a);
        end
        wait_gnt(dbg ? 2 : 1, ok);
        bus.rd_req  = 1'b0;
        bus.dbg_req = 1'b0;
        if (!ok) begin
            check({name, "/rd_gnt_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({name, "/addr_err"}, 32'(bus.addr_err), 32'(exp_err));
        check({name, "/other_gnt"}, 32'(dbg ? bus.rd_gnt : bus.dbg_gnt), 32'd0);
        tick();
        check({name, "/rvalid_early"}, 32'(bus.rvalid), 32'd0);
        tick();
        check({name, "/rvalid"}, 32'(bus.rvalid), 32'd1);
        check({name, "/rdata"}, 32'(bus.rdata), 32'(exp_d));
    endtask

    task automatic check_clear_sweep(input string name);
        int b;
        bit we;
        for (int c = 0; c < CLEAR_EDGES; c++) begin
            if (c > 0) tick();
            b  = c / (WR_HOLD + 1);
            we = (c % (WR_HOLD + 1)) < WR_HOLD;
            check({name, "/lo_we"}, 32'(lo_we), 32'(we && b < LOWER_BYTES));
            check({name, "/hi_we"}, 32'(hi_we), 32'(we && b >= LOWER_BYTES));
            if (b < LOWER_BYTES) check({name, "/lo_addr"}, 32'(lo_addr), 32'(b));
            else                 check({name, "/hi_addr"}, 32'(hi_addr), 32'(b - 64));
            check({name, "/clear_done_early"}, 32'(bus.clear_done), 32'd0);
            check({name, "/gnt_in_clear"}, 32'(bus.wr_gnt | bus.rd_gnt | bus.dbg_gnt), 32'd0);
            check({name, "/wr_done_in_clear"}, 32'(bus.wr_done), 32'd0);
        end
        tick();
        check({name, "/clear_done"}, 32'(bus.clear_done), 32'd1);
        check({name, "/we_after"}, 32'({lo_we, hi_we}), 32'd0);
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        vec_t vecs [16];
        int   exp_ord [6];
        int   got_ord [6];
        int   n;
        int   t_wg, t_wd, t_rg, t_rv;
        logic [7:0] rv_data;
        bit   seen_done;
        bit   seen_gnt;
        bit   ok;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        bus.dbg_req = 1'b0; bus.dbg_addr = '0;

        // Reset state
        tick();
        tick();
        check("rst/busy", 32'(bus.busy), 32'd1);
        check("rst/clear_done", 32'(bus.clear_done), 32'd0);
        check("rst/rdata", 32'(bus.rdata), 32'd0);
        check("rst/pulses", 32'({bus.wr_gnt, bus.rd_gnt, bus.dbg_gnt, bus.rvalid, bus.wr_done, bus.addr_err}), 32'd0);
        check("rst/we", 32'({lo_we, hi_we}), 32'b10);
        check("rst/mem_wdata", 32'(mem_wdata), 32'd0);
        rst_n = 1'b1;

        check_clear_sweep("clear");
        check("clear/busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < MEM_BYTES; i++)
            check("clear/bank_byte", 32'(i < LOWER_BYTES ? lo_mem[i] : hi_mem[i - 64]), 32'd0);

        // Vector table: op, addr, wdata, expected rdata, expected addr_err
        vecs[0]  = '{0,  70, 8'h5A, 8'h00, 1'b0};
        vecs[1]  = '{1,  70, 8'h00, 8'h5A, 1'b0};
        vecs[2]  = '{0,   0, 8'h33, 8'h00, 1'b0};
        vecs[3]  = '{0,  63, 8'hC3, 8'h00, 1'b0};
        vecs[4]  = '{0,  64, 8'h7E, 8'h00, 1'b0};
        vecs[5]  = '{0,  95, 8'hE1, 8'h00, 1'b0};
        vecs[6]  = '{1,   0, 8'h00, 8'h33, 1'b0};
        vecs[7]  = '{1,  63, 8'h00, 8'hC3, 1'b0};
        vecs[8]  = '{2,  64, 8'h00, 8'h7E, 1'b0};
        vecs[9]  = '{1,  95, 8'h00, 8'hE1, 1'b0};
        vecs[10] = '{0,  96, 8'hFF, 8'h00, 1'b1};
        vecs[11] = '{1,  96, 8'h00, 8'h00, 1'b1};
        vecs[12] = '{0, 100, 8'hAA, 8'h00, 1'b1};
        vecs[13] = '{1, 127, 8'h00, 8'h00, 1'b1};
        vecs[14] = '{2,   1, 8'h00, 8'h00, 1'b0};
        vecs[15] = '{1,  70, 8'h00, 8'h5A, 1'b0};
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].op == 0) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].exp_err, $sformatf("vec%0d", i));
                if (!vecs[i].exp_err) ref_mem[vecs[i].addr] = vecs[i].data;
            end else begin
                do_read(vecs[i].addr, vecs[i].op == 2, vecs[i].exp_data, vecs[i].exp_err,
                        $sformatf("vec%0d", i));
            end
        end

        // Write and read presented together on the same address: write goes first
        t_wg = -1; t_wd = -1; t_rg = -1; t_rv = -1; rv_data = 8'h00;
        bus.wr_req = 1'b1; bus.wr_addr = 7'd3; bus.wr_data = 8'h11;
        bus.rd_req = 1'b1; bus.rd_addr = 7'd3;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick();
            if (bus.wr_gnt && t_wg < 0) begin t_wg = cyc; bus.wr_req = 1'b0; end
            if (bus.wr_done && t_wd < 0) t_wd = cyc;
            if (bus.rd_gnt && t_rg < 0) begin t_rg = cyc; bus.rd_req = 1'b0; end
            if (bus.rvalid && t_rv < 0) begin t_rv = cyc; rv_data = bus.rdata; end
        end
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        ref_mem[3] = 8'h11;
        check("same/wr_gnt_cycle", 32'(t_wg), 32'd1);
        check("same/wr_done_cycle", 32'(t_wd), 32'd4);
        check("same/rd_gnt_cycle", 32'(t_rg), 32'd5);
        check("same/rvalid_cycle", 32'(t_rv), 32'd7);
        check("same/rdata", 32'(rv_data), 32'h11);

        // Predictor holds its request; debug wins after four lost arbitrations
        exp_ord[0] = 1; exp_ord[1] = 1; exp_ord[2] = 1; exp_ord[3] = 1; exp_ord[4] = 2; exp_ord[5] = 1;
        n = 0;
        bus.rd_req = 1'b1; bus.rd_addr = 7'd5;
        bus.dbg_req = 1'b1; bus.dbg_addr = 7'd64;
        for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
            tick();
            if (bus.rd_gnt) begin got_ord[n] = 1; n++; end
            else if (bus.dbg_gnt) begin got_ord[n] = 2; n++; bus.dbg_req = 1'b0; end
        end
        bus.rd_req = 1'b0; bus.dbg_req = 1'b0;
        repeat (4) tick();
        check("starve/grant_count", 32'(n), 32'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("starve/grant%0d", i), 32'(i < n ? got_ord[i] : 0), 32'(exp_ord[i]));

        // Random traffic against the reference byte array
        for (int i = 0; i < 80; i++) begin
            int         op;
            int         a;
            logic [7:0] d;
            logic       oor;
            op  = int'($urandom_range(0, 2));
            a   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(96, 127)) : int'($urandom_range(0, 95));
            d   = 8'($urandom_range(0, 255));
            oor = (a >= MEM_BYTES);
            if (op == 0) begin
                do_write(a, d, oor, "rnd_wr");
                if (!oor) ref_mem[a] = d;
            end else begin
                do_read(a, op == 2, oor ? 8'h00 : ref_mem[a], oor, "rnd_rd");
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        // Reset pulse during the hold phase of a write to address 10
        do_write(20, 8'h3C, 1'b0, "pre_rst_wr");
        do_read(20, 1'b0, 8'h3C, 1'b0, "pre_rst_rd");
        bus.wr_req = 1'b1; bus.wr_addr = 7'd10; bus.wr_data = 8'h77;
        wait_gnt(0, ok);
        bus.wr_req = 1'b0;
        check("midrst/wr_gnt", 32'(ok), 32'd1);
        tick();
        check("midrst/we_hold", 32'(lo_we), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.rd_req = 1'b1; bus.rd_addr = 7'd10;
        check("midrst/rdata_reset", 32'(bus.rdata), 32'd0);
        check("midrst/busy", 32'(bus.busy), 32'd1);
        check("midrst/clear_done", 32'(bus.clear_done), 32'd0);
        check_clear_sweep("reclear");
        seen_done = bus.wr_done;
        seen_gnt  = bus.wr_gnt | bus.dbg_gnt;
        check("reclear/no_wr_done", 32'(seen_done), 32'd0);
        check("reclear/no_other_gnt", 32'(seen_gnt), 32'd0);
        tick();
        check("reclear/pending_rd_gnt", 32'(bus.rd_gnt), 32'd1);
        bus.rd_req = 1'b0;
        tick();
        tick();
        check("reclear/rvalid", 32'(bus.rvalid), 32'd1);
        check("reclear/rdata_addr10", 32'(bus.rdata), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/weight_mem_sched.md
Name: weight_mem_sched

Overview:
Sequencer and arbiter for the perceptron weight store. The store is two single-port latch-memory banks: a lower bank of 64 bytes and an upper bank of MEM_BYTES-64 bytes. This block owns every bank control pin. After reset it clears all weights to 0x00. It then serves three requesters, in order: trainer writes, predictor reads and debug-dump reads. It applies fixed write timing, bank steering, out-of-range protection and a starvation guard for the debug port.

Parameters:
MEM_BYTES, 96, total weight bytes (65..128)
LOWER_BYTES, 64, size of lower bank; addresses >= LOWER_BYTES go to upper bank
ADDR_W, 7, requester address width
WR_HOLD, 2, cycles mem write-enable is held high per write (1..3)
DBG_STARVE, 4, consecutive lost arbitrations after which debug beats predictor

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
wr_req  in  1  trainer write request (level, held until wr_gnt)
wr_addr  in  ADDR_W  trainer byte address
wr_data  in  8  trainer write data
wr_gnt  out  1  one-cycle grant to trainer
wr_done  out  1  one-cycle pulse: write fully committed
rd_req  in  1  predictor read request
rd_addr  in  ADDR_W  predictor address
rd_gnt  out  1  one-cycle grant to predictor
dbg_req  in  1  debug read request
dbg_addr  in  ADDR_W  debug address
dbg_gnt  out  1  one-cycle grant to debug
rdata  out  8  read data (shared by rd/dbg)
rvalid  out  1  one-cycle pulse: rdata valid for the last granted read
addr_err  out  1  one-cycle pulse: granted address >= MEM_BYTES
busy  out  1  high whenever state != IDLE
clear_done  out  1  level; high once the post-reset clear finishes
lo_addr  out  6  lower bank address
lo_we  out  1  lower bank write enable
hi_addr  out  ADDR_W-1  upper bank address (addr - LOWER_BYTES)
hi_we  out  1  upper bank write enable
mem_wdata  out  8  shared bank write data
lo_rdata  in  8  lower bank read data
hi_rdata  in  8  upper bank read data

Behaviour:
- Reset values:
  - state=CLEAR, internal addr=0, wdata=0x00, lo_we=1.
  - All grants, rvalid, wr_done and addr_err are 0; rdata=0x00; clear_done=0; busy=1.
- Bank steering (all registered):
  - addr < LOWER_BYTES: lo_addr=addr[5:0]; only lo_we may be set.
  - Otherwise: hi_addr=addr-LOWER_BYTES; only hi_we may be set.
  - The inactive bank's we is always 0.
- Write sequence (shared by CLEAR and WRITE), per byte:
  - we high for WR_HOLD cycles, then 1 release cycle with we=0.
  - addr and mem_wdata stay stable through all WR_HOLD+1 cycles.
- CLEAR state:
  - Writes 0x00 to addresses 0..MEM_BYTES-1 in order.
  - clear_done rises on the edge ending the last release cycle: edge MEM_BYTES*(WR_HOLD+1) after rst_n goes high (288 with defaults). State then goes to IDLE.
  - No grants are issued during CLEAR; requests stay pending.
- IDLE arbitration: requests are sampled only in IDLE. Priority is wr > rd > dbg. Exception: when dbg_starve_cnt >= DBG_STARVE, dbg beats rd but still not wr.
- dbg_starve_cnt:
  - Increments on each IDLE arbitration where dbg_req=1 and another requester wins, saturating at DBG_STARVE.
  - Clears when dbg is granted or when dbg_req=0.
- Grant edge:
  - The selected gnt goes high for exactly one cycle.
  - Address (and wr_data for writes) is latched on the same edge.
  - For a write, we rises on that same edge.
  - The requester must drop req while gnt is high. A req still high on the next return to IDLE is treated as a new transaction.
- WRITE:
  - Runs the write sequence, then wr_done pulses in the cycle after release and the state returns to IDLE.
  - Grant to next grant is WR_HOLD+2 cycles (4 with defaults).
- READ:
  - Address is driven during the gnt cycle (RD_ADDR), then held for one RD_WAIT cycle.
  - On the edge ending RD_WAIT, rdata is captured from the selected bank, rvalid pulses, and the state returns to IDLE.
  - rvalid is high 2 cycles after gnt; back-to-back reads run at a 3-cycle rate.
- Out of range (addr >= MEM_BYTES):
  - The request is still granted, and addr_err pulses in the same cycle as gnt.
  - Write: both we stay 0 and wr_done still pulses on schedule.
  - Read: rdata=0x00 with rvalid on schedule.
- wr and rd in the same IDLE cycle, even to the same address: the write completes first. The next read therefore returns the new value.
- rst_n low at any time, including mid-write or mid-read:
  - All registers return to reset values next edge and the clear sweep restarts from address 0.
  - A write cut off mid-sequence is not reported (no wr_done).
- rdata holds its last value between rvalid pulses; it changes only on an rvalid edge or on reset.

Test Plan:
- Reset release, no requests -> lo_we/hi_we pattern 1,1,0 per byte for addresses 0..95, all bytes read 0x00, clear_done rises at edge 288, no gnt before that.
- After clear: write 0x5A to addr 70, then read addr 70 -> hi_we pulses 2 cycles with hi_addr=6, lo_we stays 0; rvalid 2 cycles after rd_gnt with rdata=0x5A.
- wr_req(addr 3, 0x11) and rd_req(addr 3) in the same cycle -> wr_gnt first, wr_done 4 cycles later, then rd_gnt; rvalid returns 0x11.
- rd_req held high continuously with dbg_req high -> predictor granted 4 times, then dbg_gnt on the 5th arbitration, then the predictor resumes.
- Write to addr 100 and read addr 127 -> addr_err pulses with each gnt, no we activity, wr_done on schedule, rdata=0x00.
- rst_n low for 1 cycle during WR_HOLD of a write to addr 10 -> no wr_done, clear restarts at addr 0, clear_done low until 288 edges after release, and addr 10 reads 0x00.
